// File: rtl/mem_defs.sv
// mem_defs: shared widths, state encoding, funct3 codes and IO-address predicate for the memory arbiter
package mem_defs;
    localparam int MEM_ADDR_WIDTH   = 32;
    localparam int MEM_LSB_ID_WIDTH = 4;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;
    function automatic logic is_io(input logic [1:0] seg);
        return seg == 2'b11;
    endfunction
endpackage

// File: rtl/mem_rr_pick.sv
// mem_rr_pick: LSB eligibility, icache starvation counter and one-hot winner {lsb, icache}
// Ports: clk/rst_in clock and async active-low reset; rdy_i global enable; arb_i arbitration
// allowed this edge; if_req_i, lsb_req_i, lsb_we_i, io_seg_i (address bits [17:16]), io_full_i
// request inputs; win_o one-hot winner, zero when arb_i is low.
module mem_rr_pick import mem_defs::*; #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic       rdy_i,
    input  logic       arb_i,
    input  logic       if_req_i,
    input  logic       lsb_req_i,
    input  logic       lsb_we_i,
    input  logic [1:0] io_seg_i,
    input  logic       io_full_i,
    output logic [1:0] win_o
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic lsb_ok, starved;
    assign lsb_ok  = lsb_req_i && !(lsb_we_i && is_io(io_seg_i) && io_full_i);
    assign starved = cnt_q >= CW'(STARVE_LIMIT);
    assign win_o   = !arb_i ? 2'b00 : (lsb_ok && !starved) ? 2'b10 : if_req_i ? 2'b01 : lsb_ok ? 2'b10 : 2'b00;
    // An LSB win while starved only happens with if_req low, which clears the count anyway
    assign cnt_d   = !rdy_i ? cnt_q : (!if_req_i || win_o[0]) ? '0 : win_o[1] ? cnt_q + CW'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache refills and LSB accesses onto the byte-serial memory engine
// Ports: clk, rst_in (async active-low), rdy_in global enable, flush, io_buffer_full;
// icache side if_req/if_addr -> if_gnt/if_done/if_data; LSB side lsb_req/we/addr/wdata/type/id
// -> lsb_gnt/lsb_done/lsb_rdata/lsb_done_id; engine side eng_en/rw/addr/wdata/type <- eng_done/eng_rdata;
// busy is high whenever a transaction is in flight or being reported.
module mem_arbiter import mem_defs::*; #(
    parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
    parameter int LSB_ID_WIDTH = MEM_LSB_ID_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    io_buffer_full,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_done,
    output logic [31:0]             if_data,
    input  logic                    lsb_req,
    input  logic                    lsb_we,
    input  logic [ADDR_WIDTH-1:0]   lsb_addr,
    input  logic [31:0]             lsb_wdata,
    input  logic [2:0]              lsb_type,
    input  logic [LSB_ID_WIDTH-1:0] lsb_id,
    output logic                    lsb_gnt,
    output logic                    lsb_done,
    output logic [31:0]             lsb_rdata,
    output logic [LSB_ID_WIDTH-1:0] lsb_done_id,
    output logic                    eng_en,
    output logic                    eng_rw,
    output logic [ADDR_WIDTH-1:0]   eng_addr,
    output logic [31:0]             eng_wdata,
    output logic [2:0]              eng_type,
    input  logic                    eng_done,
    input  logic [31:0]             eng_rdata,
    output logic                    busy
);
    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    kill_q, kill_d;
    logic                    rw_q, rw_d;
    logic                    if_gnt_q, if_gnt_d;
    logic                    lsb_gnt_q, lsb_gnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [2:0]              typ_q, typ_d;
    logic [LSB_ID_WIDTH-1:0] id_q, id_d;
    logic                    arb, done;
    logic [1:0]              win;

    // A flush in IDLE suppresses the grant at that edge
    assign arb = rdy_in && !flush && state_q == ST_IDLE;

    mem_rr_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk       (clk),
        .rst_in    (rst_in),
        .rdy_i     (rdy_in),
        .arb_i     (arb),
        .if_req_i  (if_req),
        .lsb_req_i (lsb_req),
        .lsb_we_i  (lsb_we),
        .io_seg_i  (lsb_addr[17:16]),
        .io_full_i (io_buffer_full),
        .win_o     (win)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        kill_d    = kill_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        typ_d     = typ_q;
        id_d      = id_q;
        if_gnt_d  = if_gnt_q;
        lsb_gnt_d = lsb_gnt_q;
        if (rdy_in) begin
            if_gnt_d  = win[0];
            lsb_gnt_d = win[1];
            // The engine always finishes; a flushed load or fetch just loses its response
            if (flush && state_q != ST_IDLE && !rw_q) kill_d = 1'b1;
            case (state_q)
                ST_IDLE: if (|win) begin
                    state_d = ST_BUSY;
                    owner_d = win[1];
                    kill_d  = 1'b0;
                    rw_d    = win[1] && lsb_we;
                    addr_d  = win[1] ? lsb_addr : if_addr;
                    wdata_d = win[1] ? lsb_wdata : '0;
                    typ_d   = win[1] ? lsb_type : F3_W;
                    id_d    = win[1] ? lsb_id : '0;
                end
                ST_BUSY: if (eng_done) begin
                    state_d = ST_RESP;
                    rdata_d = eng_rdata;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            kill_q    <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            typ_q     <= '0;
            id_q      <= '0;
            if_gnt_q  <= 1'b0;
            lsb_gnt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            kill_q    <= kill_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            typ_q     <= typ_d;
            id_q      <= id_d;
            if_gnt_q  <= if_gnt_d;
            lsb_gnt_q <= lsb_gnt_d;
        end
    end

    assign busy        = state_q != ST_IDLE;
    assign if_gnt      = if_gnt_q;
    assign lsb_gnt     = lsb_gnt_q;
    assign eng_en      = state_q == ST_BUSY;
    assign eng_rw      = eng_en && rw_q;
    assign eng_addr    = eng_en ? addr_q : '0;
    assign eng_wdata   = eng_en ? wdata_q : '0;
    assign eng_type    = eng_en ? typ_q : '0;
    assign done        = state_q == ST_RESP && !kill_q;
    assign if_done     = done && !owner_q;
    assign if_data     = if_done ? rdata_q : '0;
    assign lsb_done    = done && owner_q;
    assign lsb_rdata   = (lsb_done && !rw_q) ? rdata_q : '0;
    assign lsb_done_id = lsb_done ? id_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_arbiter;
    import mem_defs::*;
    logic        clk = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, flush = 1'b0, io_buffer_full = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_done;
    logic [31:0] if_data;
    logic        lsb_req = 1'b0, lsb_we = 1'b0;
    logic [31:0] lsb_addr = '0, lsb_wdata = '0;
    logic [2:0]  lsb_type = '0;
    logic [3:0]  lsb_id = '0;
    logic        lsb_gnt, lsb_done;
    logic [31:0] lsb_rdata;
    logic [3:0]  lsb_done_id;
    logic        eng_en, eng_rw;
    logic [31:0] eng_addr, eng_wdata;
    logic [2:0]  eng_type;
    logic        eng_done = 1'b0;
    logic [31:0] eng_rdata = '0;
    logic        busy;
    int passed = 0, total = 0, eng_lat = 1, ecnt = 0;

    mem_arbiter dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_type(lsb_type), .lsb_id(lsb_id), .lsb_gnt(lsb_gnt), .lsb_done(lsb_done),
        .lsb_rdata(lsb_rdata), .lsb_done_id(lsb_done_id), .eng_en(eng_en), .eng_rw(eng_rw),
        .eng_addr(eng_addr), .eng_wdata(eng_wdata), .eng_type(eng_type), .eng_done(eng_done),
        .eng_rdata(eng_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Engine: eng_done rises in the eng_lat-th cycle of eng_en and lasts one cycle
    initial forever begin
        @(negedge clk);
        if (eng_done) eng_done = 1'b0;
        else if (eng_en && rdy_in) begin
            ecnt++;
            if (ecnt >= eng_lat) begin
                eng_done  = 1'b1;
                eng_rdata = $urandom;
                ecnt      = 0;
            end
        end else if (!eng_en) ecnt = 0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; lsb_req = 1'b0; lsb_we = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    function automatic logic [141:0] outs();
        return {if_gnt, lsb_gnt, eng_en, eng_rw, eng_addr, eng_wdata, eng_type, if_done, if_data,
                lsb_done, lsb_rdata, lsb_done_id, busy};
    endfunction

    task automatic test_reset();
        rst_in = 1'b0;
        if_req = 1'b1; if_addr = 32'h40;
        lsb_req = 1'b1; lsb_addr = 32'h80;
        tick();
        tick();
        total++;
        if (outs() !== '0) $display("FAIL reset_outputs: got %h, required 0", outs());
        else passed++;
        rst_in = 1'b1;
        if_req = 1'b0; lsb_req = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || eng_en !== 1'b0) $display("FAIL reset_idle: got busy=%b eng_en=%b, required 0 0", busy, eng_en);
        else passed++;
    endtask

    task automatic test_simultaneous();
        int t_done = -1, t_ign = -1;
        logic [31:0] rd = '0, got_rd = '0;
        logic [3:0] got_id = '0;
        logic [35:0] ieng = '0;
        do_reset();
        eng_lat = 3;
        if_req = 1'b1; if_addr = 32'h400;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h1000; lsb_type = F3_W; lsb_id = 4'd5;
        tick();
        total++;
        if ({lsb_gnt, if_gnt, eng_en} !== 3'b101 || eng_addr !== 32'h1000)
            $display("FAIL sim_lsb_first: got lsb_gnt=%b if_gnt=%b eng_en=%b addr=%h, required 1 0 1 00001000", lsb_gnt, if_gnt, eng_en, eng_addr);
        else passed++;
        lsb_req = 1'b0;
        for (int c = 0; c < 30 && t_ign < 0; c++) begin
            if (eng_done && t_done < 0) rd = eng_rdata;
            if (lsb_done && t_done < 0) begin t_done = c; got_rd = lsb_rdata; got_id = lsb_done_id; end
            if (if_gnt) begin t_ign = c; if_req = 1'b0; ieng = {eng_rw, eng_type, eng_addr}; end
            tick();
        end
        total++;
        if (t_done < 0 || got_rd !== rd || got_id !== 4'd5)
            $display("FAIL sim_lsb_done: got seen=%0d rdata=%h id=%0d, required rdata=%h id=5", t_done, got_rd, got_id, rd);
        else passed++;
        total++;
        if (t_done < 0 || t_ign - t_done != 2)
            $display("FAIL sim_if_after: got done@%0d if_gnt@%0d, required if_gnt 2 cycles after done", t_done, t_ign);
        else passed++;
        total++;
        if (ieng !== {1'b0, F3_W, 32'h400}) $display("FAIL sim_if_operands: got %h, required %h", ieng, {1'b0, F3_W, 32'h400});
        else passed++;
    endtask

    task automatic test_starvation();
        int n = 0, nl = 0, both = 0;
        logic [6:0] seq = '0;
        do_reset();
        eng_lat = 1;
        if_req = 1'b1; if_addr = 32'h800;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h2000; lsb_id = 4'd0;
        for (int c = 0; c < 80 && n < 7; c++) begin
            tick();
            if (lsb_gnt && if_gnt) both++;
            if (lsb_gnt) begin
                seq = {seq[5:0], 1'b0}; n++; nl++;
                lsb_id = lsb_id + 4'd1; lsb_addr = lsb_addr + 32'd4;
                if (nl == 6) lsb_req = 1'b0;
            end
            if (if_gnt) begin seq = {seq[5:0], 1'b1}; n++; if_req = 1'b0; end
        end
        total++;
        if (n != 7 || both != 0) $display("FAIL starve_count: got grants=%0d overlaps=%0d, required 7 0", n, both);
        else passed++;
        total++;
        if (seq !== 7'b0000100) $display("FAIL starve_order: got %b (1=icache), required 0000100", seq);
        else passed++;
    endtask

    task automatic test_io_gating();
        int early = 0, got = 0;
        logic [64:0] seen = '0;
        do_reset();
        eng_lat = 2;
        io_buffer_full = 1'b1;
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h30000; lsb_wdata = 32'h55; lsb_type = F3_W; lsb_id = 4'd7;
        if_req = 1'b1; if_addr = 32'h80;
        tick();
        total++;
        if (if_gnt !== 1'b1 || lsb_gnt !== 1'b0) $display("FAIL io_if_first: got if_gnt=%b lsb_gnt=%b, required 1 0", if_gnt, lsb_gnt);
        else passed++;
        if_req = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (lsb_gnt) early++;
        end
        total++;
        if (early != 0) $display("FAIL io_blocked: got %0d store grants while full, required 0", early);
        else passed++;
        io_buffer_full = 1'b0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            tick();
            if (lsb_gnt) begin got = 1; seen = {eng_rw, eng_addr, eng_wdata}; lsb_req = 1'b0; end
        end
        total++;
        if (got != 1 || seen !== {1'b1, 32'h30000, 32'h55})
            $display("FAIL io_store_grant: got granted=%0d eng=%h, required 1 %h", got, seen, {1'b1, 32'h30000, 32'h55});
        else passed++;
    endtask

    task automatic test_flush_fetch();
        int en_n = 0, last = -1, ifd = 0, tg = -1;
        do_reset();
        eng_lat = 4;
        if_req = 1'b1; if_addr = 32'h200;
        tick();
        total++;
        if (if_gnt !== 1'b1 || eng_addr !== 32'h200) $display("FAIL ff_grant: got if_gnt=%b addr=%h, required 1 00000200", if_gnt, eng_addr);
        else passed++;
        if_req = 1'b0;
        flush = 1'b1;
        for (int c = 0; c < 20 && tg < 0; c++) begin
            if (c == 1) begin
                flush = 1'b0;
                lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h300; lsb_id = 4'd2;
            end
            if (lsb_gnt) begin tg = c; lsb_req = 1'b0; end
            else if (eng_en) begin en_n++; last = c; end
            if (if_done) ifd++;
            tick();
        end
        total++;
        if (en_n != 4 || ifd != 0) $display("FAIL ff_killed: got eng_en cycles=%0d if_done=%0d, required 4 0", en_n, ifd);
        else passed++;
        total++;
        if (tg < 0 || tg - last != 3) $display("FAIL ff_next_grant: got gap=%0d, required 3 cycles after last eng_en", tg - last);
        else passed++;
    endtask

    task automatic test_flush_store();
        int seen = 0;
        logic [35:0] res = '0;
        do_reset();
        eng_lat = 3;
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h100; lsb_wdata = 32'hdeadbeef; lsb_type = F3_W; lsb_id = 4'd9;
        tick();
        total++;
        if ({lsb_gnt, eng_rw, eng_addr, eng_wdata} !== {2'b11, 32'h100, 32'hdeadbeef})
            $display("FAIL fs_grant: got gnt=%b rw=%b addr=%h wdata=%h, required 1 1 00000100 deadbeef", lsb_gnt, eng_rw, eng_addr, eng_wdata);
        else passed++;
        lsb_req = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 15 && seen == 0; c++) begin
            if (lsb_done) begin seen = 1; res = {lsb_done_id, lsb_rdata}; end
            tick();
        end
        total++;
        if (seen != 1 || res !== {4'd9, 32'h0}) $display("FAIL fs_done: got seen=%0d id/rdata=%h, required 1 %h", seen, res, {4'd9, 32'h0});
        else passed++;
    endtask

    task automatic test_rdy_hold();
        int seen = 0, held = 0;
        do_reset();
        eng_lat = 2;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h40; lsb_id = 4'd3;
        tick();
        lsb_req = 1'b0;
        for (int c = 0; c < 15 && seen == 0; c++) begin
            tick();
            if (lsb_done) seen = 1;
        end
        rdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (lsb_done && lsb_done_id == 4'd3) held++;
        end
        rdy_in = 1'b1;
        tick();
        total++;
        if (seen != 1 || held != 3) $display("FAIL rdy_held: got seen=%0d held=%0d, required 1 3", seen, held);
        else passed++;
        total++;
        if (lsb_done !== 1'b0 || busy !== 1'b0) $display("FAIL rdy_release: got lsb_done=%b busy=%b, required 0 0", lsb_done, busy);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        eng_lat = 4;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h500; lsb_id = 4'd6;
        tick();
        lsb_req = 1'b0;
        tick();
        total++;
        if (eng_en !== 1'b1) $display("FAIL ar_busy: got eng_en=%b, required 1", eng_en);
        else passed++;
        #1 rst_in = 1'b0;
        #1;
        total++;
        if (outs() !== '0) $display("FAIL ar_clear: got %h, required 0", outs());
        else passed++;
        tick();
        rst_in = 1'b1;
    endtask

    task automatic test_random(input int n);
        int ph = 0, st = 0;
        logic own = 1'b0, kill = 1'b0, we = 1'b0, eg_i = 1'b0, eg_l = 1'b0, lsb_ok, tl, ti, rsp;
        logic [31:0] a = '0, wd = '0, rd = '0;
        logic [2:0] ty = '0;
        logic [3:0] id = '0;
        logic [141:0] exp_v;
        do_reset();
        for (int c = 0; c < n; c++) begin
            rsp = ph == 2 && !kill;
            exp_v = {eg_i, eg_l, ph == 1, ph == 1 && we, ph == 1 ? a : 32'h0, ph == 1 ? wd : 32'h0,
                     ph == 1 ? ty : 3'b0, rsp && !own, (rsp && !own) ? rd : 32'h0, rsp && own,
                     (rsp && own && !we) ? rd : 32'h0, (rsp && own) ? id : 4'h0, ph != 0};
            total++;
            if (outs() !== exp_v) $display("FAIL rand_cycle_%0d: got %h, required %h", c, outs(), exp_v);
            else passed++;
            eng_lat = int'($urandom_range(1, 4));
            if (eg_i) if_req = 1'b0;
            if (eg_l) lsb_req = 1'b0;
            if (!if_req && $urandom_range(0, 3) == 0) begin if_req = 1'b1; if_addr = $urandom; end
            if (!lsb_req && $urandom_range(0, 2) == 0) begin
                lsb_req   = 1'b1;
                lsb_we    = 1'($urandom);
                lsb_addr  = ($urandom_range(0, 2) == 0) ? (32'h30000 | ($urandom & 32'hffff)) : ($urandom & 32'hfcffff);
                lsb_wdata = $urandom;
                lsb_type  = 3'($urandom_range(0, 5));
                lsb_id    = 4'($urandom);
            end
            if ($urandom_range(0, 4) == 0) io_buffer_full = ~io_buffer_full;
            flush = $urandom_range(0, 9) == 0;
            eg_i = 1'b0;
            eg_l = 1'b0;
            lsb_ok = lsb_req && !(lsb_we && lsb_addr[17:16] == 2'b11 && io_buffer_full);
            if (ph == 0) begin
                if (!flush) begin
                    tl = lsb_ok && (st < 4 || !if_req);
                    ti = if_req && !tl;
                    if (tl || ti) begin
                        own = tl; eg_l = tl; eg_i = ti; kill = 1'b0;
                        we = tl && lsb_we;
                        a  = tl ? lsb_addr : if_addr;
                        wd = tl ? lsb_wdata : 32'h0;
                        ty = tl ? lsb_type : 3'b010;
                        id = tl ? lsb_id : 4'h0;
                        ph = 1;
                        st = ti ? 0 : (st < 4 ? st + 1 : 4);
                    end
                end
            end else begin
                if (flush && !we) kill = 1'b1;
                if (ph == 1) begin
                    if (eng_done) begin rd = eng_rdata; ph = 2; end
                end else ph = 0;
            end
            if (!if_req) st = 0;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_starvation();
        test_io_gating();
        test_flush_fetch();
        test_flush_store();
        test_rdy_hold();
        test_async_reset();
        test_random(3000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single byte-serial memory engine between the instruction-cache refill port and the load/store buffer, one transaction at a time. The block holds each transaction's operands for its full duration. It gates IO stores on `io_buffer_full` and discards speculative responses after a pipeline flush. It sits between `icache`/`lsb` and the memory engine, and replaces the ad-hoc `lsb2mem_en`/`cache2mem_upd_en` priority inside the engine.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `LSB_ID_WIDTH`, 4, LSB entry tag width.
- `STARVE_LIMIT`, 4, maximum consecutive LSB grants while icache is waiting.
- `clk`  in  1  single clock, rising edge.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global enable; when low, all state holds and no pulses are emitted.
- `flush`  in  1  misprediction flush.
- `io_buffer_full`  in  1  UART buffer full.
- `if_req`  in  1  icache refill request, level, held until `if_gnt`.
- `if_addr`  in  ADDR_WIDTH  refill PC.
- `if_gnt`  out  1  one-cycle acceptance pulse.
- `if_done`  out  1  one-cycle completion pulse.
- `if_data`  out  32  fetched word, valid with `if_done`.
- `lsb_req`  in  1  LSB request, level, held until `lsb_gnt`.
- `lsb_we`  in  1  1 = store.
- `lsb_addr`  in  ADDR_WIDTH  access address.
- `lsb_wdata`  in  32  store data.
- `lsb_type`  in  3  funct3 size/sign code.
- `lsb_id`  in  LSB_ID_WIDTH  load tag.
- `lsb_gnt`  out  1  acceptance pulse.
- `lsb_done`  out  1  completion pulse.
- `lsb_rdata`  out  32  load result.
- `lsb_done_id`  out  LSB_ID_WIDTH  tag of the completed access.
- `eng_en`  out  1  engine request, level.
- `eng_rw`  out  1  1 = write.
- `eng_addr`  out  ADDR_WIDTH  engine address.
- `eng_wdata`  out  32  engine write data.
- `eng_type`  out  3  engine funct3 code.
- `eng_done`  in  1  engine completion pulse.
- `eng_rdata`  in  32  assembled engine result.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Reset: state IDLE; all outputs 0; starvation count 0; owner 0; kill 0.
- States and transitions:
  - IDLE: arbitrate at each edge. A winner moves the state to BUSY.
  - BUSY: wait for `eng_done`, then go to RESP.
  - RESP: emit the done pulse, then go to IDLE.
- LSB eligibility: `lsb_req` && !(`lsb_we` && `lsb_addr[17:16]==2'b11` && `io_buffer_full`).
- Arbitration order:
  - If the LSB is eligible and the starvation count is below STARVE_LIMIT, the LSB wins.
  - Otherwise `if_req` wins.
  - Otherwise the eligible LSB wins.
- Starvation count:
  - Increments on each LSB grant made while `if_req` is high.
  - Clears on an icache grant or when `if_req` is low.
  - Saturates at STARVE_LIMIT.
- Latching on grant: the block latches addr, rw, wdata, type, id and owner.
  - An icache grant forces rw=0 and type=3'b010.
- `eng_*` outputs are driven only from the latched values and are 0 outside BUSY.
- Flush behaviour:
  - In IDLE: no request is granted at that edge.
  - In BUSY or RESP: the engine transaction still runs to completion and is never aborted. The kill flag is set unless the transaction is a store.
  - A killed transaction produces no `if_done`/`lsb_done`.
  - Stores are never killed.
- `lsb_done` fires for both loads and stores; `lsb_rdata` is 0 for stores.

## Timing
- Arbitrating edge T (state IDLE): the grant pulse and `eng_en` go high in cycle T+1.
- `eng_en` stays high through the cycle in which `eng_done` is sampled high.
- At edge D (`eng_done`=1): `eng_rdata` is captured and `eng_en` drops.
  - Done pulse plus data/id are valid in cycle D+1 (RESP).
  - IDLE at D+2; the next grant is possible at edge D+2.
- Minimum spacing between back-to-back transactions is engine latency + 2 cycles.
- `eng_done` outside BUSY is ignored.
- With `rdy_in`=0, all registers hold. A pulse already high stays high until `rdy_in` returns, then lasts one cycle.
- Asynchronous reset mid-transaction returns the block to IDLE immediately. The engine must be reset by the same signal.

## Structure
- Shared `mem_defs` package holds:
  - the state enum;
  - the IO address predicate (bits [17:16]==2'b11);
  - the funct3 constants;
  - ADDR/LSB_ID widths matching `util.v`.
- One natural sub-module: `mem_rr_pick`, containing the eligibility and starvation-counter logic and producing a one-hot winner.

## Test plan
- Simultaneous requests: `if_req`=1 and an eligible LSB load at 0x1000 in IDLE.
  - `lsb_gnt` at T+1, `eng_addr`=0x1000.
  - Icache is granted after the LSB completes.
- Starvation: `if_req` held while the LSB issues 6 back-to-back loads.
  - Exactly 4 LSB grants, then `if_gnt`, then the remaining LSB grants.
- IO gating: store to 0x30000 with `io_buffer_full`=1 and `if_req`=1.
  - Icache is granted; the store is granted only after `io_buffer_full` drops.
- Flush during an icache fetch of 0x200 (engine latency 4).
  - `eng_en` stays high 4 cycles; `if_done` is never asserted; the next request is granted at D+2.
- Flush during a store of 0xdeadbeef to 0x100.
  - `lsb_done` is still pulsed with `lsb_done_id` correct.
- `rdy_in` low for 3 cycles during RESP.
  - `lsb_done` is held, then asserted for exactly 1 active cycle.
  - Async reset asserted mid-BUSY: all outputs 0 before the next edge.
